// File: rtl/apb_pkg.sv
// apb_pkg: shared types and constants for the APB memory completer.
//   apb_slv_state_e     : bus-phase state of the completer FSM
//   RESP_OKAY/RESP_ERR  : PSLVERR encodings
//   MAX_WAIT_STATES     : largest supported programmable wait-state count
//   MAX_RD_LATENCY      : largest supported memory read latency
//   ctr_width()         : width of a down-counter able to hold 0..max_count
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_slv_state_e;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  localparam int MAX_WAIT_STATES = 15;
  localparam int MAX_RD_LATENCY  = 3;

  // Never returns 0, so a counter for a zero maximum still has one bit.
  function automatic int ctr_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/apb_slv_wait_ctr.sv
// apb_slv_wait_ctr: loadable down-counter with a zero flag.
// The load value is visible on count in the load cycle itself, so a zero load
// flags zero immediately (zero-wait completion in the first ACCESS cycle).
//   clk, rst  : clock, asynchronous active-high reset
//   load      : take load_val as the count for this cycle
//   load_val  : value to load
//   dec       : step the count down at the end of this cycle
//   count     : count in effect for the current cycle
//   zero      : count == 0
module apb_slv_wait_ctr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  assign count = load ? load_val : cnt_q;
  assign zero  = (count == '0);

  // Saturates at zero; the next transfer always reloads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load || dec) begin
      cnt_q <= zero ? '0 : (count - W'(1));
    end
  end

endmodule

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB4 completer bridging one APB port onto a single-port
// synchronous memory, with programmable wait states, read-latency
// compensation, back-to-back transfers and abort on protocol violation.
//
// Optional feature macro: APB_SLV_PROT_EN
//   defined   -> prot port present; unprivileged (prot[0]=0) access at
//                addr >= PROT_BASE returns slverr without touching memory
//   undefined -> no prot port; only the out-of-range check applies
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   sel/enable/write/addr/wdata/strobe/prot   APB requester side (PSEL ...)
//   ready/slverr/rdata                        APB completer response
//   mem_wr/mem_rd   one-cycle memory strobes
//   mem_be/mem_address/mem_data_in            memory request fields
//   mem_data_out    memory read data (held until the next mem_rd)
//   dbg_state       bus phase of the current cycle (apb_slv_state_e)
//
// Handshake: a transfer is one cycle of sel & ~enable (SETUP) followed by
// sel & enable (ACCESS) held until ready=1. Dropping sel or enable before
// ready aborts the transfer silently. slverr and rdata are meaningful only
// while ready=1 and are 0 otherwise.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0,
  parameter int RD_LATENCY  = 0,
  parameter int PROT_BASE   = MEM_DEPTH / 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel,
  input  logic                enable,
  input  logic                write,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] strobe,
`ifdef APB_SLV_PROT_EN
  input  logic [2:0]          prot,
`endif
  output logic                ready,
  output logic                slverr,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_wr,
  output logic                mem_rd,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_data_in,
  input  logic [DATA_W-1:0]   mem_data_out,
  output logic [1:0]          dbg_state
);

  localparam int SW = DATA_W / 8;
  // Out-of-range settings are clamped to what the counter is sized for.
  localparam int WS = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES;
  localparam int RL = (RD_LATENCY > MAX_RD_LATENCY) ? MAX_RD_LATENCY : RD_LATENCY;
  localparam int CW = ctr_width(WS + RL);

  localparam logic [CW-1:0]   WS_C    = CW'(WS);
  localparam logic [CW-1:0]   RL_C    = CW'(RL);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

  // ---------------------------------------------------------------------
  // Error decode on the live bus (used in the first ACCESS cycle)
  // ---------------------------------------------------------------------
  logic err_live;

`ifdef APB_SLV_PROT_EN
  localparam logic [ADDR_W:0] PROT_L = (ADDR_W + 1)'(PROT_BASE);
  logic unused_prot;
  assign unused_prot = ^prot[2:1];
  assign err_live = ({1'b0, addr} >= DEPTH_L) |
                    (({1'b0, addr} >= PROT_L) & ~prot[0]);
`else
  localparam logic [ADDR_W:0] unused_prot_base = (ADDR_W + 1)'(PROT_BASE);
  assign err_live = ({1'b0, addr} >= DEPTH_L);
`endif

  // ---------------------------------------------------------------------
  // FSM: state_q is the phase of the previous cycle, state the phase of
  // the current one (decoded from state_q and the live bus).
  // ---------------------------------------------------------------------
  apb_slv_state_e state_q, state;
  logic           done_q;

  always_comb begin
    state = IDLE;
    case (state_q)
      IDLE:   if (sel && !enable) state = SETUP;
      SETUP:  if (sel) state = enable ? ACCESS : SETUP;
      ACCESS: begin
        if (done_q) begin
          if (sel && !enable) state = SETUP;   // back-to-back
        end else if (sel && enable) begin
          state = ACCESS;                      // still waiting
        end
      end
      default: state = IDLE;
    endcase
  end

  logic entry, in_access;
  assign in_access = (state == ACCESS);
  assign entry     = in_access && (state_q == SETUP);

  // Transfer attributes: live bus on entry, captured copy afterwards.
  logic              write_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [SW-1:0]     strobe_q;

  logic              cur_write, cur_err;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [SW-1:0]     cur_strobe;

  assign cur_write  = entry ? write    : write_q;
  assign cur_err    = entry ? err_live : err_q;
  assign cur_addr   = entry ? addr     : addr_q;
  assign cur_wdata  = entry ? wdata    : wdata_q;
  assign cur_strobe = entry ? strobe   : strobe_q;

  // Reads wait out the memory latency on top of the wait states; writes
  // and error transfers only see the wait states.
  logic [CW-1:0] load_val, ctr_count;
  logic          ctr_zero;
  assign load_val = WS_C + ((!cur_write && !cur_err) ? RL_C : '0);

  apb_slv_wait_ctr #(
    .W (CW)
  ) u_wait_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (entry),
    .load_val (load_val),
    .dec      (in_access && !entry),
    .count    (ctr_count),
    .zero     (ctr_zero)
  );

  logic done, wr_fire, rd_fire;
  assign done    = in_access && ctr_zero;
  assign wr_fire = done && cur_write && !cur_err && (|cur_strobe);
  // Issue the read exactly RD_LATENCY cycles before completion.
  assign rd_fire = in_access && !cur_write && !cur_err && (ctr_count == RL_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strobe_q <= '0;
    end else begin
      state_q <= state;
      done_q  <= done;
      if (entry) begin
        write_q  <= write;
        err_q    <= err_live;
        addr_q   <= addr;
        wdata_q  <= wdata;
        strobe_q <= strobe;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: everything is 0 outside its active cycle.
  // ---------------------------------------------------------------------
  always_comb begin
    ready       = done;
    slverr      = RESP_OKAY;
    rdata       = '0;
    mem_wr      = wr_fire;
    mem_rd      = rd_fire;
    mem_be      = '0;
    mem_address = '0;
    mem_data_in = '0;
    if (done && cur_err) slverr = RESP_ERR;
    if (done && !cur_write && !cur_err) rdata = mem_data_out;
    if (wr_fire) begin
      mem_be      = cur_strobe;
      mem_address = cur_addr;
      mem_data_in = cur_wdata;
    end else if (rd_fire) begin
      mem_be      = '1;
      mem_address = cur_addr;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: directed bench for apb_mem_slave.
//   Instance A: MEM_DEPTH=1024, WAIT_STATES=0, RD_LATENCY=0, PROT_BASE=512
//   Instance B: MEM_DEPTH=16,   WAIT_STATES=2, RD_LATENCY=1
// Build with +define+APB_SLV_PROT_EN to exercise the privileged region.
module tb_apb_mem_slave;
  import apb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
`ifdef APB_SLV_PROT_EN
  localparam bit PROT_ON = 1'b1;
`else
  localparam bit PROT_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared bus ----------------
  logic          a_sel, b_sel, enable, write;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [3:0]    strobe;
`ifdef APB_SLV_PROT_EN
  logic [2:0]    prot;
`endif

  logic          a_ready, a_slverr, a_mem_wr, a_mem_rd;
  logic [DW-1:0] a_rdata, a_mem_data_in, a_mem_data_out;
  logic [3:0]    a_mem_be;
  logic [AW-1:0] a_mem_address;
  logic [1:0]    a_dbg_state;

  logic          b_ready, b_slverr, b_mem_wr, b_mem_rd;
  logic [DW-1:0] b_rdata, b_mem_data_in, b_mem_data_out;
  logic [3:0]    b_mem_be;
  logic [AW-1:0] b_mem_address;
  logic [1:0]    b_dbg_state;

  apb_mem_slave #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(1024),
    .WAIT_STATES(0), .RD_LATENCY(0), .PROT_BASE(512)
  ) u_dut_a (
    .clk(clk), .rst(rst), .sel(a_sel), .enable(enable), .write(write),
    .addr(addr), .wdata(wdata), .strobe(strobe),
`ifdef APB_SLV_PROT_EN
    .prot(prot),
`endif
    .ready(a_ready), .slverr(a_slverr), .rdata(a_rdata),
    .mem_wr(a_mem_wr), .mem_rd(a_mem_rd), .mem_be(a_mem_be),
    .mem_address(a_mem_address), .mem_data_in(a_mem_data_in),
    .mem_data_out(a_mem_data_out), .dbg_state(a_dbg_state)
  );

  apb_mem_slave #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(16),
    .WAIT_STATES(2), .RD_LATENCY(1), .PROT_BASE(0)
  ) u_dut_b (
    .clk(clk), .rst(rst), .sel(b_sel), .enable(enable), .write(write),
    .addr(addr), .wdata(wdata), .strobe(strobe),
`ifdef APB_SLV_PROT_EN
    .prot(prot),
`endif
    .ready(b_ready), .slverr(b_slverr), .rdata(b_rdata),
    .mem_wr(b_mem_wr), .mem_rd(b_mem_rd), .mem_be(b_mem_be),
    .mem_address(b_mem_address), .mem_data_in(b_mem_data_in),
    .mem_data_out(b_mem_data_out), .dbg_state(b_dbg_state)
  );

  // ---------------- memory models ----------------
  // A: zero-latency memory. B: one-cycle registered read.
  logic [DW-1:0] mem_a [1024];
  logic [DW-1:0] mem_b [16];
  logic [DW-1:0] a_hold, b_dout;
  bit            mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem_a[i] <= 32'hC0DE_0000 | i;
      for (int i = 0; i < 16; i++)   mem_b[i] <= '0;
      mem_b[3] <= 32'hA5A5_0003;
      a_hold   <= '0;
      b_dout   <= '0;
      mem_init <= 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (a_mem_wr && a_mem_be[i]) mem_a[a_mem_address[9:0]][8*i +: 8] <= a_mem_data_in[8*i +: 8];
        if (b_mem_wr && b_mem_be[i]) mem_b[b_mem_address[3:0]][8*i +: 8] <= b_mem_data_in[8*i +: 8];
      end
      if (a_mem_rd) a_hold <= mem_a[a_mem_address[9:0]];
      if (b_mem_rd) b_dout <= mem_b[b_mem_address[3:0]];
    end
  end

  assign a_mem_data_out = a_mem_rd ? mem_a[a_mem_address[9:0]] : a_hold;
  assign b_mem_data_out = b_dout;

  // ---------------- target mux ----------------
  bit tgt = 1'b0;
  logic          s_ready, s_slverr, s_mem_wr, s_mem_rd;
  logic [DW-1:0] s_rdata, s_mem_data_in;
  logic [3:0]    s_mem_be;
  logic [AW-1:0] s_mem_address;
  logic [1:0]    s_dbg_state;
  assign s_ready       = tgt ? b_ready       : a_ready;
  assign s_slverr      = tgt ? b_slverr      : a_slverr;
  assign s_mem_wr      = tgt ? b_mem_wr      : a_mem_wr;
  assign s_mem_rd      = tgt ? b_mem_rd      : a_mem_rd;
  assign s_rdata       = tgt ? b_rdata       : a_rdata;
  assign s_mem_data_in = tgt ? b_mem_data_in : a_mem_data_in;
  assign s_mem_be      = tgt ? b_mem_be      : a_mem_be;
  assign s_mem_address = tgt ? b_mem_address : a_mem_address;
  assign s_dbg_state   = tgt ? b_dbg_state   : a_dbg_state;

  // ---------------- scoreboard / reference ----------------
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] ref_a [1024];
  logic [DW-1:0] ref_b [16];
  int n_tests = 0;
  int n_fail  = 0;

  int            o_rdy_cyc, o_wr_cnt, o_wr_cyc, o_rd_cnt, o_rd_cyc, o_stray;
  logic [DW-1:0] o_rdata, o_wr_data;
  logic [AW-1:0] o_wr_addr, o_rd_addr;
  logic [3:0]    o_wr_be, o_rd_be;
  logic          o_slverr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ws_of(input bit t);
    return t ? 2 : 0;
  endfunction

  function automatic int rl_of(input bit t);
    return t ? 1 : 0;
  endfunction

  function automatic bit exp_err(input bit t, input int a, input logic [2:0] p);
    if (t) return (a >= 16);
    return (a >= 1024) || (PROT_ON && (a >= 512) && !p[0]);
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, ".ctl"},  {s_ready, s_slverr, s_mem_wr, s_mem_rd, s_mem_be, s_dbg_state}, 64'h0);
    check({tag, ".data"}, {s_rdata, s_mem_data_in}, 64'h0);
    check({tag, ".addr"}, s_mem_address, 64'h0);
  endtask

  // ---------------- driver ----------------
  task automatic xfer(input bit t, input bit wr, input int a, input logic [DW-1:0] d,
                      input logic [3:0] s, input logic [2:0] p);
    tgt = t;
    o_rdy_cyc = -1; o_wr_cnt = 0; o_wr_cyc = -1; o_rd_cnt = 0; o_rd_cyc = -1; o_stray = 0;
    o_rdata = '0; o_slverr = 1'b0; o_wr_data = '0; o_wr_addr = '0; o_wr_be = '0;
    o_rd_addr = '0; o_rd_be = '0;
    @(posedge clk); #1;
    a_sel = !t; b_sel = t; enable = 1'b0; write = wr;
    addr = AW'(a); wdata = d; strobe = s;
`ifdef APB_SLV_PROT_EN
    prot = p;
`endif
    @(negedge clk);
    if (s_ready || s_mem_wr || s_mem_rd || s_slverr) o_stray++;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      enable = 1'b1;
      @(negedge clk);
      if (s_mem_wr) begin
        o_wr_cnt++; o_wr_cyc = c; o_wr_be = s_mem_be; o_wr_addr = s_mem_address; o_wr_data = s_mem_data_in;
      end
      if (s_mem_rd) begin
        o_rd_cnt++; o_rd_cyc = c; o_rd_be = s_mem_be; o_rd_addr = s_mem_address;
      end
      if (s_ready) begin
        o_rdy_cyc = c; o_rdata = s_rdata; o_slverr = s_slverr;
        break;
      end
      if (s_slverr) o_stray++;
    end
  endtask

  task automatic bus_idle();
    @(posedge clk); #1;
    a_sel = 1'b0; b_sel = 1'b0; enable = 1'b0; write = 1'b0; strobe = '0;
  endtask

  task automatic do_write(input bit t, input int a, input logic [DW-1:0] d, input logic [3:0] s,
                          input logic [2:0] p, input bit b2b, input string tag);
    bit err = exp_err(t, a, p);
    bit exp_wr = !err && (s != 4'h0);
    if (exp_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (s[i]) begin
          if (t) ref_b[a][8*i +: 8] = d[8*i +: 8];
          else   ref_a[a][8*i +: 8] = d[8*i +: 8];
        end
      end
    end
    xfer(t, 1'b1, a, d, s, p);
    check({tag, ".rdy_cyc"}, o_rdy_cyc, 1 + ws_of(t));
    check({tag, ".slverr"},  o_slverr, err);
    check({tag, ".wr_cnt"},  o_wr_cnt, exp_wr ? 1 : 0);
    check({tag, ".rd_cnt"},  o_rd_cnt, 0);
    check({tag, ".stray"},   o_stray, 0);
    if (exp_wr) begin
      check({tag, ".wr_cyc"}, o_wr_cyc, 1 + ws_of(t));
      check({tag, ".wr_req"}, {o_wr_be, o_wr_addr, o_wr_data}, {4'(s), 16'(a), d});
    end
    if (!b2b) bus_idle();
  endtask

  task automatic do_read(input bit t, input int a, input logic [2:0] p, input string tag);
    bit err = exp_err(t, a, p);
    if (err)    exp_q.push_back('0);
    else if (t) exp_q.push_back(ref_b[a]);
    else        exp_q.push_back(ref_a[a]);
    xfer(t, 1'b0, a, '0, 4'h0, p);
    check({tag, ".rdy_cyc"}, o_rdy_cyc, 1 + ws_of(t) + (err ? 0 : rl_of(t)));
    check({tag, ".slverr"},  o_slverr, err);
    check({tag, ".rd_cnt"},  o_rd_cnt, err ? 0 : 1);
    check({tag, ".wr_cnt"},  o_wr_cnt, 0);
    check({tag, ".stray"},   o_stray, 0);
    if (!err) begin
      check({tag, ".rd_cyc"}, o_rd_cyc, 1 + ws_of(t));
      check({tag, ".rd_req"}, {o_rd_be, o_rd_addr}, {4'hF, 16'(a)});
    end
    check({tag, ".rdata"}, o_rdata, exp_q.pop_front());
    bus_idle();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n_act;
    for (int i = 0; i < 1024; i++) ref_a[i] = 32'hC0DE_0000 | i;
    for (int i = 0; i < 16; i++)   ref_b[i] = '0;
    ref_b[3] = 32'hA5A5_0003;
    a_sel = 1'b0; b_sel = 1'b0; enable = 1'b0; write = 1'b0;
    addr = '0; wdata = '0; strobe = '0;
`ifdef APB_SLV_PROT_EN
    prot = 3'b000;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tgt = 1'b0; #1 check_quiet("reset_a");
    tgt = 1'b1; #1 check_quiet("reset_b");
    @(posedge clk); #1 rst = 1'b0;

    // Zero-wait write then read-back.
    do_write(1'b0, 5, 32'hDEAD_BEEF, 4'hF, 3'b001, 1'b0, "a_wr5");
    do_read (1'b0, 5, 3'b001, "a_rd5");

    // Out of range.
    do_write(1'b0, 1024, 32'h1111_1111, 4'hF, 3'b001, 1'b0, "a_wr_oor");
    do_read (1'b0, 1024, 3'b001, "a_rd_oor");

    // Back-to-back partial writes to one word.
    do_write(1'b0, 1, 32'h1111_2222, 4'h3, 3'b001, 1'b1, "a_b2b0");
    do_write(1'b0, 1, 32'h3333_4444, 4'hC, 3'b001, 1'b0, "a_b2b1");
    do_read (1'b0, 1, 3'b001, "a_rd1");

    // Zero strobe: completes OKAY, memory untouched.
    do_write(1'b0, 7, 32'hFFFF_FFFF, 4'h0, 3'b001, 1'b0, "a_wr_s0");
    do_read (1'b0, 7, 3'b001, "a_rd7");

    // Random privileged writes with read-back.
    for (int k = 0; k < 4; k++) begin
      int a;
      logic [DW-1:0] d;
      logic [3:0] s;
      a = $urandom_range(0, 1023);
      d = $urandom;
      s = 4'($urandom_range(1, 15));
      do_write(1'b0, a, d, s, 3'b001, 1'b0, "a_rnd_wr");
      do_read (1'b0, a, 3'b001, "a_rnd_rd");
    end

    // Wait states and read latency.
    do_read (1'b1, 3, 3'b001, "b_rd3");
    do_write(1'b1, 4, 32'h0BAD_F00D, 4'hF, 3'b001, 1'b0, "b_wr4");
    do_read (1'b1, 4, 3'b001, "b_rd4");
    do_read (1'b1, 16, 3'b001, "b_rd_oor");

    // Abort: enable dropped in the second ACCESS cycle.
    tgt = 1'b1; n_act = 0;
    @(posedge clk); #1;
    b_sel = 1'b1; enable = 1'b0; write = 1'b1; addr = 16'd6; wdata = 32'h1234_5678; strobe = 4'hF;
    @(negedge clk); if (s_ready || s_mem_wr) n_act++;
    @(posedge clk); #1 enable = 1'b1;
    @(negedge clk); if (s_ready || s_mem_wr) n_act++;
    @(posedge clk); #1 enable = 1'b0;
    @(negedge clk); if (s_ready || s_mem_wr) n_act++;
    check("abort.state", s_dbg_state, IDLE);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1 b_sel = 1'b0;
      @(negedge clk); if (s_ready || s_mem_wr) n_act++;
    end
    check("abort.quiet", n_act, 0);
    do_read(1'b1, 6, 3'b001, "b_rd6_after_abort");

    // Reset in the cycle the read strobe would fire.
    tgt = 1'b1;
    @(posedge clk); #1;
    b_sel = 1'b1; enable = 1'b0; write = 1'b0; addr = 16'd3; strobe = 4'h0;
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    #1 check_quiet("rst_mid");
    @(posedge clk); #1 b_sel = 1'b0; enable = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    do_read(1'b1, 3, 3'b001, "b_rd3_after_rst");

    // Privileged region (error only when the feature is built in).
    do_write(1'b0, 600, 32'h5555_AAAA, 4'hF, 3'b000, 1'b0, "a_wr600_user");
    do_write(1'b0, 600, 32'h6666_7777, 4'hF, 3'b001, 1'b0, "a_wr600_priv");
    do_read (1'b0, 600, 3'b000, "a_rd600_user");
    do_read (1'b0, 600, 3'b001, "a_rd600_priv");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
